// File: rtl/reg_scoreboard.sv
// Register-status scoreboard for a 5-stage pipeline.
// Tracks the writers sitting in EX and MEM, publishes a per-register
// forwarding status to the ID stage, and raises a load-use stall that
// holds ID and drops a bubble into EX.
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int RW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_in,
  input  logic          flush,
  input  logic          id_valid,
  input  logic          id_writes,
  input  logic          id_is_load,
  input  logic [RW-1:0] id_rd,
  input  logic [RW-1:0] id_ra,
  input  logic [RW-1:0] id_rb,
  input  logic          id_use_ra,
  input  logic          id_use_rb,
  output logic [2:0]    register_invalid [NREG-1:0],
  output logic          hazard_stall,
  output logic [1:0]    inflight
);

  // Status codes as seen by the instruction in ID.
  localparam logic [2:0] ST_REGFILE = 3'd0;  // WB is covered by regfile bypass
  localparam logic [2:0] ST_LOAD_EX = 3'd1;  // load result not yet available
  localparam logic [2:0] ST_FWD_EX  = 3'd2;  // forward from EX/MEM latch
  localparam logic [2:0] ST_FWD_MEM = 3'd3;  // forward from MEM/WB latch

  // EX slot keeps the load flag; MEM only needs validity and destination,
  // because any writer in MEM is forwardable regardless of its kind.
  logic          ex_v_reg;
  logic [RW-1:0] ex_rd_reg;
  logic          ex_ld_reg;
  logic          mem_v_reg;
  logic [RW-1:0] mem_rd_reg;

  logic [2:0]    status_a;
  logic [2:0]    status_b;

  // Per-register status: the EX writer is younger, so it takes precedence.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_status
      always_comb begin
        register_invalid[gi] = ST_REGFILE;
        if (ex_v_reg && (ex_rd_reg == RW'(gi))) begin
          register_invalid[gi] = ex_ld_reg ? ST_LOAD_EX : ST_FWD_EX;
        end else if (mem_v_reg && (mem_rd_reg == RW'(gi))) begin
          register_invalid[gi] = ST_FWD_MEM;
        end
      end
    end
  endgenerate

  // Load-use detection on the sources the ID instruction actually reads.
  always_comb begin
    status_a     = register_invalid[id_ra];
    status_b     = register_invalid[id_rb];
    hazard_stall = id_valid && !flush &&
                   ((id_use_ra && (status_a == ST_LOAD_EX)) ||
                    (id_use_rb && (status_b == ST_LOAD_EX)));
  end

  // Occupancy comes straight from the slot valid bits, never from ID.
  assign inflight = {1'b0, ex_v_reg} + {1'b0, mem_v_reg};

  // Slot advance: reset > freeze > flush/hazard bubble > normal issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v_reg   <= 1'b0;
      ex_rd_reg  <= '0;
      ex_ld_reg  <= 1'b0;
      mem_v_reg  <= 1'b0;
      mem_rd_reg <= '0;
    end else if (!stall_in) begin
      // MEM always takes whatever EX held; the old MEM entry retires to WB
      // and is no longer tracked.
      mem_v_reg  <= ex_v_reg;
      mem_rd_reg <= ex_rd_reg;
      if (flush || hazard_stall) begin
        ex_v_reg <= 1'b0;
      end else begin
        ex_v_reg  <= id_valid && id_writes;
        ex_rd_reg <= id_rd;
        ex_ld_reg <= id_is_load;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: the stimulus process pushes the
// hand-computed response for each cycle, a monitor pops and compares on
// the falling edge.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall_in;
  logic       flush;
  logic       id_valid;
  logic       id_writes;
  logic       id_is_load;
  logic [2:0] id_rd;
  logic [2:0] id_ra;
  logic [2:0] id_rb;
  logic       id_use_ra;
  logic       id_use_rb;
  logic [2:0] register_invalid [7:0];
  logic       hazard_stall;
  logic [1:0] inflight;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    bit         all_zero;
    int         idx;
    logic [2:0] st;
    logic       hz;
    logic [1:0] inf;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(8), .RW(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_in         (stall_in),
    .flush            (flush),
    .id_valid         (id_valid),
    .id_writes        (id_writes),
    .id_is_load       (id_is_load),
    .id_rd            (id_rd),
    .id_ra            (id_ra),
    .id_rb            (id_rb),
    .id_use_ra        (id_use_ra),
    .id_use_rb        (id_use_rb),
    .register_invalid (register_invalid),
    .hazard_stall     (hazard_stall),
    .inflight         (inflight)
  );

  task automatic idle();
    stall_in   = 1'b0;
    flush      = 1'b0;
    id_valid   = 1'b0;
    id_writes  = 1'b0;
    id_is_load = 1'b0;
    id_rd      = 3'd0;
    id_ra      = 3'd0;
    id_rb      = 3'd0;
    id_use_ra  = 1'b0;
    id_use_rb  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] rd, input logic ld);
    idle();
    id_valid   = 1'b1;
    id_writes  = 1'b1;
    id_is_load = ld;
    id_rd      = rd;
  endtask

  task automatic expect_st(input string nm, input int idx, input logic [2:0] st,
                           input logic hz, input logic [1:0] inf);
    exp_t e;
    e.name = nm; e.all_zero = 1'b0; e.idx = idx; e.st = st; e.hz = hz; e.inf = inf;
    exp_q.push_back(e);
  endtask

  task automatic expect_zero(input string nm, input logic hz, input logic [1:0] inf);
    exp_t e;
    e.name = nm; e.all_zero = 1'b1; e.idx = 0; e.st = 3'd0; e.hz = hz; e.inf = inf;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the status outputs are always presented, so every pending
  // expectation for the current cycle is checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.all_zero) begin
          int nz = 0;
          for (int r = 0; r < 8; r++) if (register_invalid[r] != 3'd0) nz++;
          total++;
          if (nz != 0) begin
            bad++;
            $display("FAIL %s all_status: nonzero entries=%0d required=0", e.name, nz);
          end
        end else begin
          total++;
          if (register_invalid[e.idx] !== e.st) begin
            bad++;
            $display("FAIL %s status[%0d]: got %0d required %0d",
                     e.name, e.idx, register_invalid[e.idx], e.st);
          end
        end
        total++;
        if (hazard_stall !== e.hz) begin
          bad++;
          $display("FAIL %s hazard_stall: got %0b required %0b", e.name, hazard_stall, e.hz);
        end
        total++;
        if (inflight !== e.inf) begin
          bad++;
          $display("FAIL %s inflight: got %0d required %0d", e.name, inflight, e.inf);
        end
        $display("check %s: st0..7=%0d%0d%0d%0d%0d%0d%0d%0d hz=%0b inf=%0d", e.name,
                 register_invalid[0], register_invalid[1], register_invalid[2],
                 register_invalid[3], register_invalid[4], register_invalid[5],
                 register_invalid[6], register_invalid[7], hazard_stall, inflight);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    idle(); expect_zero("reset", 1'b0, 2'd0); tick();

    // ALU chain on r1
    wr(3'd1, 1'b0); expect_st("alu_c0", 1, 3'd0, 1'b0, 2'd0); tick();
    idle();         expect_st("alu_c1", 1, 3'd2, 1'b0, 2'd1); tick();
    idle();         expect_st("alu_c2", 1, 3'd3, 1'b0, 2'd1); tick();
    idle();         expect_st("alu_c3", 1, 3'd0, 1'b0, 2'd0); tick();

    // Load-use on r2 via ra: one-cycle stall, then forward from MEM/WB
    wr(3'd2, 1'b1); expect_st("ldu_c0", 2, 3'd0, 1'b0, 2'd0); tick();
    idle(); id_valid = 1'b1; id_ra = 3'd2; id_use_ra = 1'b1;
    expect_st("ldu_c1", 2, 3'd1, 1'b1, 2'd1); tick();
    expect_st("ldu_c2", 2, 3'd3, 1'b0, 2'd1); tick();
    idle();         expect_st("ldu_c3", 2, 3'd0, 1'b0, 2'd0); tick();

    // Load-use on r0 via rb (r0 is an ordinary register here)
    wr(3'd0, 1'b1); tick();
    idle(); id_valid = 1'b1; id_rb = 3'd0; id_use_rb = 1'b1;
    expect_st("ldr0_c1", 0, 3'd1, 1'b1, 2'd1); tick();
    expect_st("ldr0_c2", 0, 3'd3, 1'b0, 2'd1); tick();
    idle(); expect_st("ldr0_c3", 0, 3'd0, 1'b0, 2'd0); tick();

    // Source matches a load but is not read: no stall
    wr(3'd7, 1'b1); tick();
    idle(); id_valid = 1'b1; id_rb = 3'd7; id_use_rb = 1'b0;
    expect_st("nouse_c1", 7, 3'd1, 1'b0, 2'd1); tick();
    idle(); expect_st("nouse_c2", 7, 3'd3, 1'b0, 2'd1); tick();
    idle(); tick();

    // Youngest writer wins on r3
    wr(3'd3, 1'b1); expect_st("young_c0", 3, 3'd0, 1'b0, 2'd0); tick();
    wr(3'd3, 1'b0); expect_st("young_c1", 3, 3'd1, 1'b0, 2'd1); tick();
    idle();         expect_st("young_c2", 3, 3'd2, 1'b0, 2'd2); tick();
    idle();         expect_st("young_c3", 3, 3'd3, 1'b0, 2'd1); tick();
    idle();         expect_st("young_c4", 3, 3'd0, 1'b0, 2'd0); tick();

    // Freeze: r4 held in EX while stall_in is high; ID writer to r0 ignored
    wr(3'd4, 1'b0); expect_st("frz_c0", 4, 3'd0, 1'b0, 2'd0); tick();
    idle(); stall_in = 1'b1; expect_st("frz_c1", 4, 3'd2, 1'b0, 2'd1); tick();
    wr(3'd0, 1'b0); stall_in = 1'b1; expect_st("frz_c2", 4, 3'd2, 1'b0, 2'd1); tick();
    idle(); stall_in = 1'b1; expect_st("frz_c3", 4, 3'd2, 1'b0, 2'd1); tick();
    idle(); expect_st("frz_c4", 4, 3'd2, 1'b0, 2'd1);
            expect_st("frz_c4r0", 0, 3'd0, 1'b0, 2'd1); tick();
    idle(); expect_st("frz_c5", 4, 3'd3, 1'b0, 2'd1); tick();
    idle(); expect_st("frz_c6", 4, 3'd0, 1'b0, 2'd0); tick();

    // Flush: r5 moves on, ID writer to r6 is discarded
    wr(3'd5, 1'b0); tick();
    wr(3'd6, 1'b0); flush = 1'b1; expect_st("fl_c1", 5, 3'd2, 1'b0, 2'd1); tick();
    idle(); expect_st("fl_c2", 5, 3'd3, 1'b0, 2'd1);
            expect_st("fl_c2r6", 6, 3'd0, 1'b0, 2'd1); tick();
    idle(); expect_st("fl_c3", 6, 3'd0, 1'b0, 2'd0); tick();

    // Flush masks a load-use hazard
    wr(3'd6, 1'b1); tick();
    idle(); flush = 1'b1; id_valid = 1'b1; id_rb = 3'd6; id_use_rb = 1'b1;
    expect_st("flhz_c1", 6, 3'd1, 1'b0, 2'd1); tick();
    idle(); expect_st("flhz_c2", 6, 3'd3, 1'b0, 2'd1); tick();
    idle(); tick();

    // Reset mid-flight with a live hazard
    wr(3'd1, 1'b0); tick();
    wr(3'd2, 1'b1); tick();
    idle(); id_valid = 1'b1; id_ra = 3'd2; id_use_ra = 1'b1; reset = 1'b1;
    expect_st("rmf_pre1", 1, 3'd3, 1'b1, 2'd2);
    expect_st("rmf_pre2", 2, 3'd1, 1'b1, 2'd2); tick();
    reset = 1'b0;
    expect_zero("rmf_post", 1'b0, 2'd0); tick();
    idle(); expect_zero("rmf_idle", 1'b0, 2'd0); tick();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
